pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline stage register with a valid/ready handshake, an optional 2-entry skid buffer, flush-to-bubble and a stall/bubble performance counter. It sits between any two pipeline stages, with ID→EXE as the first user. It replaces hard-wired per-field stage registers: callers concatenate their fields into `in_ctrl` and `in_data`. Upstream stalls when `in_ready` is low, which replaces the old `freeze` input. Control bits are forced to zero whenever the output carries a bubble, so a flushed or empty stage can never write back or touch memory.

## Interface
- `CTRL_W`, default 8: control-field width (WB_EN, MEM_R_EN, MEM_W_EN, B, S, …); zero in a bubble.
- `DATA_W`, default 128: payload width (PC, operand values, immediates, dest/src ids, SR).
- `SKID`, default 1: 1 = 2-entry skid buffer with registered `in_ready`; 0 = single entry with combinational `in_ready`.
- `CNT_W`, default 16: width of the bubble counter.
- `clk` input 1: clock.
- `rst` input 1: reset, asynchronous, active-high.
- `flush` input 1: synchronous; discards all held and incoming entries.
- `in_valid` input 1: upstream has an entry.
- `in_ready` output 1: stage can accept an entry.
- `in_ctrl` input CTRL_W: incoming control field.
- `in_data` input DATA_W: incoming payload.
- `out_valid` output 1: head entry is valid.
- `out_ready` input 1: downstream accepts the head entry.
- `out_ctrl` output CTRL_W: head control field; 0 when `out_valid`=0.
- `out_data` output DATA_W: head payload.
- `bubble_cnt` output CNT_W: saturating count of cycles with `out_valid`=0.
- `cnt_clr` input 1: synchronous clear of `bubble_cnt`.

## Operation
- Transfers:
  - Input transfer = `in_valid & in_ready`.
  - Output transfer = `out_valid & out_ready`.
  - Entries leave in strict FIFO order; no entry is duplicated or dropped except by `flush`.
- FSM with SKID=1, states EMPTY, ONE, TWO:
  - EMPTY → ONE on an input transfer.
  - ONE → TWO on input without output.
  - ONE → EMPTY on output without input.
  - ONE → ONE on both; the head is replaced by the incoming entry.
  - TWO → ONE on an output transfer; no input is possible in TWO.
- SKID=0: states EMPTY and ONE only. Input is accepted when EMPTY or when an output transfer happens in the same cycle.
- `in_ready`:
  - SKID=1: registered, equal to (next_state != TWO). No combinational path from `out_ready`.
  - SKID=0: `~out_valid | out_ready`.
- Flush:
  - Has priority over all transfers.
  - Next state is EMPTY, and every entry register is cleared to 0 (ctrl and data).
  - An input presented in the flush cycle is discarded.
  - An output transfer in the flush cycle counts as completed.
- Reset values: state EMPTY, `out_valid` 0, `out_ctrl` 0, `out_data` 0, `bubble_cnt` 0, `in_ready` 1.
- `bubble_cnt`:
  - Increments each cycle `out_valid`=0 and saturates at all-ones.
  - `cnt_clr` takes priority over increment.
  - Flush does not clear it.

## Timing
- Latency is 1 cycle from input transfer to `out_valid` when EMPTY.
- Throughput is 1 entry/cycle when `out_ready` is held high (state alternates EMPTY/ONE or stays ONE).
- SKID=1: after `out_ready` falls, one more input is absorbed (state TWO) and `in_ready` drops the following cycle. After `out_ready` rises in TWO, `in_ready` returns 1 cycle later.
- Flush at cycle N: `out_valid`=0 and `out_ctrl`=0 at N+1. With SKID=1, `in_ready`=1 at N+1.
- Reset mid-operation: all outputs take reset values immediately (asynchronous); in-flight entries are lost.
- All outputs except SKID=0 `in_ready` are driven directly from flops.

## Structure
- The shared pipeline package holds:
  - the ctrl-field bit-index localparams (WB_EN, MEM_R_EN, MEM_W_EN, B, S);
  - the `stage_state_t` enum {EMPTY, ONE, TWO};
  - the default widths.
- One sub-module, `pipe_entry_reg`, holds a single ctrl+data entry with load enable and synchronous clear. It is instantiated once for SKID=0 and twice (head, skid) for SKID=1.
- The FSM, the ready logic and the counter live in the top module.

## Test plan
- Reset, then single entry: assert `rst` mid-cycle; outputs go 0 with `in_ready`=1 without waiting for a clock edge. Then send ctrl=8'h1F, data=128'hA5…: it appears 1 cycle later, and `out_ctrl`=8'h1F only while `out_valid`=1.
- Full-rate streaming: `out_ready`=1 and 100 back-to-back entries with incrementing data → 100 outputs in order, no gaps after the first, `bubble_cnt`=1.
- Backpressure, SKID=1: hold `out_ready`=0 for 5 cycles while `in_valid`=1 → exactly 2 entries accepted and `in_ready` low from cycle 3. Release → both drain in order and `in_ready` rises 1 cycle later.
- Flush in TWO: `flush` with `in_valid`=1 → next cycle `out_valid`=0 and `out_ctrl`=0; the flushed entries and the concurrent input never appear; the following entry passes normally.
- Counter: 70000 idle cycles with CNT_W=16 → `bubble_cnt`=16'hFFFF (saturated). `cnt_clr` → 0 next cycle; `cnt_clr` and increment together → 0.
- SKID=0 build: `out_ready`=0 with a valid head → `in_ready`=0 in the same cycle. `out_ready`=1 → simultaneous accept and replace with no bubble.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline definitions: ctrl-field bit positions, stage occupancy states
// and the default field widths used by the stage registers.
package pipe_stage_reg_pkg;

  localparam int CTRL_W_DEF = 8;
  localparam int DATA_W_DEF = 128;
  localparam int CNT_W_DEF  = 16;

  // Bit positions inside the ctrl field
  localparam int CTRL_WB_EN    = 0;
  localparam int CTRL_MEM_R_EN = 1;
  localparam int CTRL_MEM_W_EN = 2;
  localparam int CTRL_B        = 3;
  localparam int CTRL_S        = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_t;

endpackage

// File: rtl/pipe_entry_reg.sv
// One ctrl+data entry register with load enable; synchronous clear wins over load.
module pipe_entry_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic [DATA_W-1:0] q_data
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_ctrl <= '0;
      q_data <= '0;
    end else if (clr) begin
      q_ctrl <= '0;
      q_data <= '0;
    end else if (load) begin
      q_ctrl <= d_ctrl;
      q_data <= d_data;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, optional 2-entry skid
// buffer, flush-to-bubble and a saturating bubble-cycle counter.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int SKID   = 1,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  bubble_cnt,
  input  logic              cnt_clr
);

  stage_state_t      state_reg, state_next;
  logic              out_valid_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              in_xfer, out_xfer;
  logic              head_load, head_clr, head_from_skid;
  logic              skid_load, skid_clr;
  logic [CTRL_W-1:0] head_ctrl, skid_ctrl, head_d_ctrl;
  logic [DATA_W-1:0] head_data, skid_data, head_d_data;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid_reg & out_ready;

  // The head is cleared whenever the stage empties, so its ctrl is already
  // zero in a bubble and can drive out_ctrl straight from the flops.
  always_comb begin
    state_next     = state_reg;
    head_load      = 1'b0;
    head_clr       = 1'b0;
    head_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clr       = 1'b0;
    if (flush) begin
      state_next = EMPTY;
      head_clr   = 1'b1;
      skid_clr   = 1'b1;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (in_xfer) begin
            state_next = ONE;
            head_load  = 1'b1;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            head_load = 1'b1;
          end else if (in_xfer) begin
            if (SKID != 0) begin
              state_next = TWO;
              skid_load  = 1'b1;
            end
          end else if (out_xfer) begin
            state_next = EMPTY;
            head_clr   = 1'b1;
          end
        end
        TWO: begin
          if (out_xfer) begin
            state_next     = ONE;
            head_load      = 1'b1;
            head_from_skid = 1'b1;
            skid_clr       = 1'b1;
          end
        end
        default: begin
          state_next = EMPTY;
          head_clr   = 1'b1;
          skid_clr   = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= EMPTY;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      out_valid_reg <= (state_next != EMPTY);
    end
  end

  assign head_d_ctrl = head_from_skid ? skid_ctrl : in_ctrl;
  assign head_d_data = head_from_skid ? skid_data : in_data;

  pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_head (
    .clk    (clk),
    .rst    (rst),
    .clr    (head_clr),
    .load   (head_load),
    .d_ctrl (head_d_ctrl),
    .d_data (head_d_data),
    .q_ctrl (head_ctrl),
    .q_data (head_data)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic in_ready_reg;

      pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
        .clk    (clk),
        .rst    (rst),
        .clr    (skid_clr),
        .load   (skid_load),
        .d_ctrl (in_ctrl),
        .d_data (in_data),
        .q_ctrl (skid_ctrl),
        .q_data (skid_data)
      );

      // Registered ready: no combinational path from out_ready upstream.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) in_ready_reg <= 1'b1;
        else     in_ready_reg <= (state_next != TWO);
      end
      assign in_ready = in_ready_reg;
    end else begin : g_single
      logic unused_skid;
      assign unused_skid = ^{skid_load, skid_clr};
      assign skid_ctrl   = '0;
      assign skid_data   = '0;
      assign in_ready    = ~out_valid_reg | out_ready;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  cnt_reg <= '0;
    else if (cnt_clr)                         cnt_reg <= '0;
    else if (!out_valid_reg && cnt_reg != '1) cnt_reg <= cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  assign out_valid  = out_valid_reg;
  assign out_ctrl   = head_ctrl;
  assign out_data   = head_data;
  assign bubble_cnt = cnt_reg;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench: SKID=1 (index 0) and SKID=0 (index 1) stages driven in parallel.
module tb_pipe_stage_reg;
  localparam int CW = 8;
  localparam int DW = 128;
  localparam int NW = 16;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          cnt_clr = 1'b0;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;

  logic          in_ready_a  [2];
  logic          out_valid_a [2];
  logic [CW-1:0] out_ctrl_a  [2];
  logic [DW-1:0] out_data_a  [2];
  logic [NW-1:0] cnt_a       [2];

  ent_t sb [2][$];
  int   cnt_m [2];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CNT_W(NW)) dut_skid (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a[0]),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid_a[0]), .out_ready(out_ready),
    .out_ctrl(out_ctrl_a[0]), .out_data(out_data_a[0]), .bubble_cnt(cnt_a[0]), .cnt_clr(cnt_clr)
  );

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .CNT_W(NW)) dut_single (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a[1]),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid_a[1]), .out_ready(out_ready),
    .out_ctrl(out_ctrl_a[1]), .out_data(out_data_a[1]), .bubble_cnt(cnt_a[1]), .cnt_clr(cnt_clr)
  );

  task automatic chk(input string name, input int d, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d: got %h expected %h", name, d, act, exp);
    end
  endtask

  // Monitor: compares each stage against its queue, then applies this cycle's transfers.
  bit exp_v, exp_r, in_x, out_x;
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        sb[d].delete();
        cnt_m[d] = 0;
      end else begin
        exp_v = (sb[d].size() != 0);
        exp_r = (d == 0) ? (sb[d].size() < 2) : (!exp_v || out_ready);
        chk("out_valid", d, DW'(out_valid_a[d]), DW'(exp_v));
        chk("in_ready", d, DW'(in_ready_a[d]), DW'(exp_r));
        chk("bubble_cnt", d, DW'(cnt_a[d]), DW'(cnt_m[d]));
        if (exp_v) begin
          chk("out_ctrl", d, DW'(out_ctrl_a[d]), DW'(sb[d][0].c));
          chk("out_data", d, out_data_a[d], sb[d][0].d);
        end else begin
          chk("bubble_ctrl", d, DW'(out_ctrl_a[d]), '0);
        end
        in_x  = in_valid && in_ready_a[d];
        out_x = out_valid_a[d] && out_ready;
        if (flush) begin
          sb[d].delete();
        end else begin
          if (out_x && sb[d].size() != 0) void'(sb[d].pop_front());
          if (in_x) sb[d].push_back({in_ctrl, in_data});
        end
        if (cnt_clr)                       cnt_m[d] = 0;
        else if (!exp_v && cnt_m[d] < 65535) cnt_m[d] = cnt_m[d] + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    flush     = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    int acc;
    logic [DW-1:0] rd;

    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Asynchronous reset in mid-cycle with entries held
    in_valid = 1'b1; in_ctrl = 8'h33; in_data = 128'h1234;
    out_ready = 1'b0;
    repeat (2) tick();
    in_valid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_out_valid", d, DW'(out_valid_a[d]), '0);
      chk("rst_out_ctrl", d, DW'(out_ctrl_a[d]), '0);
      chk("rst_out_data", d, out_data_a[d], '0);
      chk("rst_cnt", d, DW'(cnt_a[d]), '0);
      chk("rst_in_ready", d, DW'(in_ready_a[d]), DW'(1'b1));
    end
    tick();
    rst = 1'b0;
    tick();

    // Single entry: visible one cycle after the transfer
    in_valid = 1'b1; in_ctrl = 8'h1F; in_data = {16{8'hA5}};
    tick();
    in_valid = 1'b0;
    chk("single_valid", 0, DW'(out_valid_a[0]), DW'(1'b1));
    chk("single_ctrl", 0, DW'(out_ctrl_a[0]), DW'(8'h1F));
    out_ready = 1'b1;
    tick();
    chk("single_gone_ctrl", 0, DW'(out_ctrl_a[0]), '0);
    drain();

    // Full-rate streaming of 100 entries
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_ctrl = CW'(i);
      in_data = DW'(i + 1000);
      tick();
    end
    in_valid = 1'b0;
    for (int d = 0; d < 2; d++) chk("stream_bubbles", d, DW'(cnt_a[d]), DW'(1));
    drain();

    // Backpressure: SKID=1 absorbs exactly two entries
    out_ready = 1'b0;
    in_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      in_ctrl = CW'(8'h40 + i);
      in_data = DW'(i + 2000);
      if (in_ready_a[0]) acc++;
      if (i == 2) chk("bp_ready_low_c3", 0, DW'(in_ready_a[0]), '0);
      tick();
    end
    chk("bp_accepted", 0, DW'(acc), DW'(2));
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("bp_ready_held", 0, DW'(in_ready_a[0]), '0);
    tick();
    chk("bp_ready_back", 0, DW'(in_ready_a[0]), DW'(1'b1));
    drain();

    // Flush while holding two entries, with a concurrent input
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_ctrl = CW'(8'h60 + i);
      in_data = DW'(i + 3000);
      tick();
    end
    flush = 1'b1;
    in_ctrl = 8'h7E; in_data = DW'(3999);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk("flush_valid", d, DW'(out_valid_a[d]), '0);
      chk("flush_ctrl", d, DW'(out_ctrl_a[d]), '0);
      chk("flush_ready", d, DW'(in_ready_a[d]), DW'(1'b1));
    end
    in_valid = 1'b1; in_ctrl = 8'h05; in_data = DW'(4000);
    tick();
    in_valid = 1'b0;
    drain();

    // SKID=0: combinational ready and replace-without-bubble
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 8'h11; in_data = DW'(5000);
    tick();
    in_valid = 1'b0;
    #1;
    chk("s0_ready_stall", 1, DW'(in_ready_a[1]), '0);
    out_ready = 1'b1;
    #1;
    chk("s0_ready_comb", 1, DW'(in_ready_a[1]), DW'(1'b1));
    in_valid = 1'b1; in_ctrl = 8'h12; in_data = DW'(5001);
    tick();
    in_valid = 1'b0;
    chk("s0_replace_valid", 1, DW'(out_valid_a[1]), DW'(1'b1));
    chk("s0_replace_data", 1, out_data_a[1], DW'(5001));
    drain();

    // Randomised traffic with occasional flush and counter clear
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 40) == 0);
      cnt_clr   = ($urandom_range(0, 60) == 0);
      in_ctrl   = CW'($urandom);
      rd        = {$urandom, $urandom, $urandom, $urandom};
      in_data   = rd;
      tick();
    end
    cnt_clr = 1'b0;
    drain();

    // Counter saturation, clear, and clear winning over increment
    repeat (70000) tick();
    for (int d = 0; d < 2; d++) chk("cnt_sat", d, DW'(cnt_a[d]), DW'(16'hFFFF));
    cnt_clr = 1'b1;
    tick();
    for (int d = 0; d < 2; d++) chk("cnt_clr", d, DW'(cnt_a[d]), '0);
    tick();
    for (int d = 0; d < 2; d++) chk("cnt_clr_vs_inc", d, DW'(cnt_a[d]), '0);
    cnt_clr = 1'b0;
    tick();
    for (int d = 0; d < 2; d++) chk("cnt_restart", d, DW'(cnt_a[d]), DW'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
